// File: rtl/signed_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor.
// The magnitudes are divided with a restoring shift-subtract loop, one
// quotient bit per cycle. The signs are then applied, and the result is
// checked against the N-bit signed range.
// Results truncate toward zero, and the remainder takes the sign of the dividend.
module signed_divider #(
   parameter int N = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic signed [2*N-1:0] dividend,
   input  logic signed [N-1:0]   divisor,
   output logic signed [N-1:0]   quotient,
   output logic signed [N-1:0]   remainder,
   output logic                  done,
   output logic                  busy,
   output logic                  div_by_zero,
   output logic                  overflow
);

   localparam int CW = $clog2(2 * N);
   localparam logic [CW-1:0]    LAST_STEP = CW'(2 * N - 1);
   // Largest quotient magnitude allowed for a negative result: 2^(N-1)
   localparam logic [2*N-1:0]   QLIM_NEG  = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
   // Largest quotient magnitude allowed for a positive result: 2^(N-1)-1
   localparam logic [2*N-1:0]   QLIM_POS  = {{(N+1){1'b0}}, {(N-1){1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // The magnitude of the most negative value is representable as unsigned.
   function automatic logic [2*N-1:0] mag_dividend(input logic [2*N-1:0] x);
      return x[2*N-1] ? (-x) : x;
   endfunction

   function automatic logic [N-1:0] mag_divisor(input logic [N-1:0] x);
      return x[N-1] ? (-x) : x;
   endfunction

   state_t                state_q, state_d;
   logic [2*N-1:0]        a_q, a_d;          // dividend magnitude / quotient bits
   logic [N-1:0]          b_q, b_d;          // divisor magnitude
   logic [N:0]            r_q, r_d;          // partial remainder
   logic [CW-1:0]         count_q, count_d;
   logic                  sd_q, sd_d;        // dividend sign
   logic                  sv_q, sv_d;        // divisor sign
   logic signed [N-1:0]   quotient_q, quotient_d;
   logic signed [N-1:0]   remainder_q, remainder_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  dbz_q, dbz_d;
   logic                  ovf_q, ovf_d;

   logic [3*N:0]          ra_shift_s;
   logic [N+1:0]          trial_s;
   logic                  neg_s;
   logic                  ovf_s;

   // Next-state and datapath logic for the divider FSM
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      r_d         = r_q;
      count_d     = count_q;
      sd_d        = sd_q;
      sv_d        = sv_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      done_d      = done_q;
      busy_d      = busy_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;

      // One restoring step: shift {R,A} left, then try subtracting B from R
      ra_shift_s = {r_q, a_q} << 1'b1;
      trial_s    = {1'b0, ra_shift_s[3*N:2*N]} - {2'b00, b_q};

      // Range check on the finished magnitude quotient
      neg_s = sd_q ^ sv_q;
      if (neg_s) begin
         ovf_s = (a_q > QLIM_NEG);
      end else begin
         ovf_s = (a_q > QLIM_POS);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (divisor == {N{1'b0}}) begin
                  state_d     = S_DONE;
                  quotient_d  = {N{1'b0}};
                  remainder_d = {N{1'b0}};
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
                  dbz_d       = 1'b1;
                  ovf_d       = 1'b0;
               end else begin
                  state_d = S_ITER;
                  a_d     = mag_dividend(dividend);
                  b_d     = mag_divisor(divisor);
                  sd_d    = dividend[2*N-1];
                  sv_d    = divisor[N-1];
                  r_d     = {(N+1){1'b0}};
                  count_d = {CW{1'b0}};
                  done_d  = 1'b0;
                  busy_d  = 1'b1;
                  dbz_d   = 1'b0;
                  ovf_d   = 1'b0;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_ITER: begin
            if (trial_s[N+1]) begin
               // Trial went negative: restore by keeping the shifted remainder
               r_d = ra_shift_s[3*N:2*N];
               a_d = {ra_shift_s[2*N-1:1], 1'b0};
            end else begin
               r_d = trial_s[N:0];
               a_d = {ra_shift_s[2*N-1:1], 1'b1};
            end
            if (count_q == LAST_STEP) begin
               state_d = S_FIX;
            end else begin
               count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         S_FIX: begin
            ovf_d = ovf_s;
            if (ovf_s) begin
               quotient_d  = {N{1'b0}};
               remainder_d = {N{1'b0}};
            end else begin
               quotient_d  = neg_s ? (-a_q[N-1:0]) : a_q[N-1:0];
               remainder_d = sd_q ? (-r_q[N-1:0]) : r_q[N-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset that abandons any operation
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         a_q         <= {(2*N){1'b0}};
         b_q         <= {N{1'b0}};
         r_q         <= {(N+1){1'b0}};
         count_q     <= {CW{1'b0}};
         sd_q        <= 1'b0;
         sv_q        <= 1'b0;
         quotient_q  <= {N{1'b0}};
         remainder_q <= {N{1'b0}};
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         r_q         <= r_d;
         count_q     <= count_d;
         sd_q        <= sd_d;
         sv_q        <= sv_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule
